// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : controller states (run / redirect flush / MUL-DIV wait)
//   OPCODE_*       : RV32I major opcodes that read rs1/rs2
//   reg_use_t      : which source registers an instruction reads
//   src_hit        : true when a used, non-x0 source matches a producer rd
package pipeline_hazard_ctrl_pkg;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      HZ_RUN     = 2'd0,
      HZ_FLUSH   = 2'd1,
      HZ_MD_WAIT = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic use_rs1;
      logic use_rs2;
   } reg_use_t;

   // x0 never carries a real dependency, so a load into x0 never stalls.
   function automatic logic src_hit(input logic       used,
                                    input logic [4:0] src,
                                    input logic [4:0] dest);
      return used && (dest != 5'd0) && (src == dest);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage hazard bundle between the pipeline and the hazard controller.
//   master : pipeline side, drives ID/EX status and MUL/DIV done, receives controls
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [6:0]       id_opcode_ip;
   logic [4:0]       id_rs1_ip;
   logic [4:0]       id_rs2_ip;
   logic             id_md_req_ip;
   logic [4:0]       ex_dest_ip;
   logic             ex_is_load_ip;
   logic             ex_redirect_ip;
   logic             md_done_ip;
   logic             md_start_op;
   logic             pc_stall_op;
   logic             if_id_stall_op;
   logic             id_ex_bubble_op;
   logic             if_id_flush_op;
   logic             md_timeout_op;
   logic [CNT_W-1:0] stall_cnt_op;

   modport master (
      output id_opcode_ip, id_rs1_ip, id_rs2_ip, id_md_req_ip,
             ex_dest_ip, ex_is_load_ip, ex_redirect_ip, md_done_ip,
      input  md_start_op, pc_stall_op, if_id_stall_op, id_ex_bubble_op,
             if_id_flush_op, md_timeout_op, stall_cnt_op
   );

   modport slave (
      input  id_opcode_ip, id_rs1_ip, id_rs2_ip, id_md_req_ip,
             ex_dest_ip, ex_is_load_ip, ex_redirect_ip, md_done_ip,
      output md_start_op, pc_stall_op, if_id_stall_op, id_ex_bubble_op,
             if_id_flush_op, md_timeout_op, stall_cnt_op
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_reg_use_decode.sv
// Combinational opcode -> source register usage decode.
//   opcode  : major opcode of the instruction in ID
//   reg_use : {use_rs1, use_rs2}
// Kept standalone so the forwarding unit can share the same decode.
module pipeline_hazard_ctrl_reg_use_decode
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output reg_use_t   reg_use
);

   always_comb begin
      reg_use = '0;
      case (opcode)
         OPCODE_OP,
         OPCODE_STORE,
         OPCODE_BRANCH: begin
            reg_use.use_rs1 = 1'b1;
            reg_use.use_rs2 = 1'b1;
         end
         OPCODE_OPIMM,
         OPCODE_LOAD,
         OPCODE_JALR: begin
            reg_use.use_rs1 = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: load-use stalls, redirect flushes and the
// MUL/DIV start/done handshake with timeout.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low
//   hz    : hazard bundle (slave side), see pipeline_hazard_ctrl_if
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HZ_RUN     | normal issue; resolves redirect > load-use > MUL/DIV start
// HZ_FLUSH   | trailing flush/bubble cycles after a redirect
// HZ_MD_WAIT | front end held while MUL/DIV runs, until done or timeout
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MD_TIMEOUT   = 64,
   parameter int CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  hz
);

   localparam int FL_TW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
   localparam int MD_TW = $clog2(MD_TIMEOUT);

   // The redirect cycle itself is spent in HZ_RUN, so the down-counter only
   // covers the remaining FLUSH_CYCLES-1 cycles (terminal count 0).
   localparam logic [FL_TW-1:0] FL_LOAD = FL_TW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
   localparam logic [MD_TW-1:0] MD_LOAD = MD_TW'(MD_TIMEOUT - 1);

   hazard_state_t    state;
   logic [FL_TW-1:0] fl_tmr;
   logic [MD_TW-1:0] md_tmr;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_cnt;

   reg_use_t         reg_use;
   logic             load_use;
   logic             md_start;
   logic             stall;
   logic             bubble;
   logic             flush;

   pipeline_hazard_ctrl_reg_use_decode u_reg_use_decode (
      .opcode  (hz.id_opcode_ip),
      .reg_use (reg_use)
   );

   assign load_use = hz.ex_is_load_ip &&
                     (src_hit(reg_use.use_rs1, hz.id_rs1_ip, hz.ex_dest_ip) ||
                      src_hit(reg_use.use_rs2, hz.id_rs2_ip, hz.ex_dest_ip));

   // Controls are Mealy so a load-use stall lands in the same cycle it is seen.
   // Gating with reset keeps every control low while reset is held, even if
   // ID still presents a MUL/DIV request.
   always_comb begin
      md_start = 1'b0;
      stall    = 1'b0;
      bubble   = 1'b0;
      flush    = 1'b0;
      if (reset) begin
         case (state)
            HZ_RUN: begin
               if (hz.ex_redirect_ip) begin
                  flush  = 1'b1;
                  bubble = 1'b1;
               end else if (load_use) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end else if (hz.id_md_req_ip) begin
                  md_start = 1'b1;
                  stall    = 1'b1;
                  bubble   = 1'b1;
               end
            end
            HZ_FLUSH: begin
               flush  = 1'b1;
               bubble = 1'b1;
            end
            HZ_MD_WAIT: begin
               // Release on done, or on the terminal timeout cycle.
               if (!hz.md_done_ip && (md_tmr != '0)) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HZ_RUN;
         fl_tmr     <= '0;
         md_tmr     <= '0;
         md_timeout <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         case (state)
            HZ_RUN: begin
               if (hz.ex_redirect_ip) begin
                  if (FLUSH_CYCLES > 1) begin
                     state  <= HZ_FLUSH;
                     fl_tmr <= FL_LOAD;
                  end
               end else if (!load_use && hz.id_md_req_ip) begin
                  state  <= HZ_MD_WAIT;
                  md_tmr <= MD_LOAD;
               end
            end
            HZ_FLUSH: begin
               if (hz.ex_redirect_ip) begin
                  fl_tmr <= FL_LOAD;
               end else if (fl_tmr == '0) begin
                  state <= HZ_RUN;
               end else begin
                  fl_tmr <= fl_tmr - FL_TW'(1);
               end
            end
            HZ_MD_WAIT: begin
               // A redirect cannot occur here (EX only holds bubbles), so it is ignored.
               if (hz.md_done_ip) begin
                  state <= HZ_RUN;
               end else if (md_tmr == '0) begin
                  state      <= HZ_RUN;
                  md_timeout <= 1'b1;
               end else begin
                  md_tmr <= md_tmr - MD_TW'(1);
               end
            end
            default: state <= HZ_RUN;
         endcase
      end
   end

   assign hz.md_start_op     = md_start;
   assign hz.pc_stall_op     = stall;
   assign hz.if_id_stall_op  = stall;
   assign hz.id_ex_bubble_op = bubble;
   assign hz.if_id_flush_op  = flush;
   assign hz.md_timeout_op   = md_timeout;
   assign hz.stall_cnt_op    = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: each directed step pushes its expected controls, a
// negedge monitor pops and compares. A narrow stall counter is used so the
// long MUL/DIV timeout run also drives the counter into saturation.
module tb_pipeline_hazard_ctrl;

   localparam int TB_CNT_W = 4;
   localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic                st;
      logic                ps;
      logic                is;
      logic                bb;
      logic                fl;
      logic                to;
      logic [TB_CNT_W-1:0] cnt;
   } obs_t;

   typedef struct {
      obs_t  v;
      string name;
   } exp_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   exp_t exp_q[$];

   logic [TB_CNT_W-1:0] exp_cnt;
   logic                exp_to;

   pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hz ();

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES (2),
      .MD_TIMEOUT   (64),
      .CNT_W        (TB_CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic [6:0] opc,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mdq, input logic [4:0] exd, input logic exl,
                       input logic redir, input logic done,
                       input logic e_start, input logic e_stall,
                       input logic e_bub, input logic e_flush,
                       input string name);
      exp_t e;
      reset             = rst;
      hz.id_opcode_ip   = opc;
      hz.id_rs1_ip      = rs1;
      hz.id_rs2_ip      = rs2;
      hz.id_md_req_ip   = mdq;
      hz.ex_dest_ip     = exd;
      hz.ex_is_load_ip  = exl;
      hz.ex_redirect_ip = redir;
      hz.md_done_ip     = done;
      if (!rst) begin
         exp_cnt = '0;
         exp_to  = 1'b0;
      end
      e.v    = '{st: e_start, ps: e_stall, is: e_stall, bb: e_bub, fl: e_flush,
                 to: exp_to, cnt: exp_cnt};
      e.name = name;
      exp_q.push_back(e);
      if (e_stall && (exp_cnt != CNT_MAX)) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string name);
      step(1'b1, 7'h13, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, name);
   endtask

   // Monitor: compares the DUT against the oldest pending expectation.
   initial begin
      exp_t e;
      obs_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{st: hz.md_start_op, ps: hz.pc_stall_op, is: hz.if_id_stall_op,
                  bb: hz.id_ex_bubble_op, fl: hz.if_id_flush_op,
                  to: hz.md_timeout_op, cnt: hz.stall_cnt_op};
            n_cmp++;
            if (a !== e.v) begin
               n_bad++;
               $display("FAIL %s: got start=%b stall=%b ifid=%b bub=%b flush=%b to=%b cnt=%0d, want start=%b stall=%b ifid=%b bub=%b flush=%b to=%b cnt=%0d",
                        e.name, a.st, a.ps, a.is, a.bb, a.fl, a.to, a.cnt,
                        e.v.st, e.v.ps, e.v.is, e.v.bb, e.v.fl, e.v.to, e.v.cnt);
            end
         end
      end
   end

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      exp_cnt = '0;
      exp_to  = 1'b0;
      reset   = 1'b0;
      hz.id_opcode_ip = 7'h13; hz.id_rs1_ip = 5'd0; hz.id_rs2_ip = 5'd0;
      hz.id_md_req_ip = 1'b0;  hz.ex_dest_ip = 5'd0; hz.ex_is_load_ip = 1'b0;
      hz.ex_redirect_ip = 1'b0; hz.md_done_ip = 1'b0;
      @(posedge clk);
      #1;

      //   rst  opc    rs1 rs2 mdq exd ld redir done | st stl bub fl
      step(0, 7'h13, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "reset");
      idle("idle");

      // Load-use on rs1 stalls exactly one cycle; x0 and unused rs2 do not.
      step(1, 7'h33, 5, 7, 0, 5, 1, 0, 0,   0, 1, 1, 0, "lu_add_rs1");
      idle("lu_release");
      step(1, 7'h33, 0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, "lu_x0");
      step(1, 7'h13, 3, 5, 0, 5, 1, 0, 0,   0, 0, 0, 0, "opimm_rs2_field");
      step(1, 7'h23, 1, 5, 0, 5, 1, 0, 0,   0, 1, 1, 0, "store_rs2");
      step(1, 7'h33, 1, 5, 0, 5, 0, 0, 0,   0, 0, 0, 0, "not_load");
      step(1, 7'h67, 9, 0, 0, 9, 1, 0, 0,   0, 1, 1, 0, "jalr_rs1");
      step(1, 7'h63, 2, 4, 0, 4, 1, 0, 0,   0, 1, 1, 0, "branch_rs2");
      step(1, 7'h37, 9, 9, 0, 9, 1, 0, 0,   0, 0, 0, 0, "lui_no_use");

      // Redirect beats load-use; flush lasts two cycles; hazards ignored in FLUSH.
      step(1, 7'h33, 5, 7, 0, 5, 1, 1, 0,   0, 0, 1, 1, "redir_over_lu");
      step(1, 7'h33, 5, 7, 1, 5, 1, 0, 0,   0, 0, 1, 1, "flush_2nd");
      idle("flush_done");

      // A second redirect during FLUSH reloads the count.
      step(1, 7'h13, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, "redir_a");
      step(1, 7'h13, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, "redir_reload");
      step(1, 7'h13, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, "reload_tail");
      idle("reload_done");

      // MUL/DIV with done: one start pulse, six stall cycles, release on done.
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   1, 1, 1, 0, "md_start");
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 1, 1, 0, "md_wait1");
      step(1, 7'h33, 1, 2, 1, 0, 0, 1, 0,   0, 1, 1, 0, "md_wait_redir_ign");
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 1, 1, 0, "md_wait3");
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 1, 1, 0, "md_wait4");
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 1, 1, 0, "md_wait5");
      step(1, 7'h33, 1, 2, 0, 0, 0, 0, 1,   0, 0, 0, 0, "md_done_release");
      step(1, 7'h13, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, "done_in_run_ign");

      // MUL/DIV without done: 64 stall cycles, then sticky timeout.
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   1, 1, 1, 0, "md_to_start");
      for (int i = 0; i < 63; i++)
         step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, "md_to_wait");
      step(1, 7'h33, 1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, "md_to_release");
      exp_to = 1'b1;
      idle("timeout_sticky1");
      idle("timeout_sticky2");
      step(1, 7'h33, 5, 7, 0, 5, 1, 0, 0,   0, 1, 1, 0, "lu_saturated");
      idle("sat_hold");

      // Reset in the middle of MD_WAIT clears everything immediately.
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   1, 1, 1, 0, "md_rst_start");
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 1, 1, 0, "md_rst_wait1");
      step(1, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 1, 1, 0, "md_rst_wait2");
      step(0, 7'h33, 1, 2, 1, 0, 0, 0, 0,   0, 0, 0, 0, "rst_mid_wait");
      idle("post_reset_run");
      step(1, 7'h33, 5, 7, 0, 5, 1, 0, 0,   0, 1, 1, 0, "post_reset_lu");
      idle("post_reset_cnt");

      for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: pending=%0d, want 0", exp_q.size());
      end
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
